// File: rtl/input_conditioner_pkg.sv
// Shared helpers for the input conditioner: debounce counter sizing.
package input_conditioner_pkg;

    // Counter width for a terminal count of cycles-1, never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One channel: stability-count debouncer followed by a registered-input edge detector.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_deb,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;

    // Any cycle of agreement restarts the count; the counter clears at its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb   <= RESET_BIT;
            r_deb_d <= RESET_BIT;
            r_cnt   <= '0;
        end else begin
            r_deb_d <= r_deb;
            if (i_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_deb <= i_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_deb & ~r_deb_d;
    assign o_fall = ~r_deb & r_deb_d;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchronizer + debouncer + edge detector for asynchronous pin inputs.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VALUE[g])
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .i_sync(sync_out[g]),
            .o_deb (debounced_out[g]),
            .o_rise(rise_pulse[g]),
            .o_fall(fall_pulse[g])
        );
    end

endmodule
